// File: rtl/rle_decode.sv
`default_nettype none
// ============================================================================
// rle_decode: expands {byte,count} run entries read from DPSRAM port A and
// writes the plaintext back through the same port.   Rev 1.0
// ============================================================================
module rle_decode #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    EXPAND = 3'd3,
    WRITE  = 3'd4,
    NEXT   = 3'd5,
    FLUSH  = 3'd6,
    FIN    = 3'd7
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [29:0]       words_left;
  logic [31:0]       byte_cnt;
  logic [1:0]        lane;
  logic              half;
  logic [31:0]       cur_word;
  logic [7:0]        run_byte;
  logic [7:0]        run_left;
  logic [31:0]       pack;
  logic [LAT_W-1:0]  lat_cnt;
  logic [15:0]       entry;
  logic              lat_hit;

  assign port_A_clk = clk;
  assign entry      = half ? cur_word[31:16] : cur_word[15:0];
  assign lat_hit    = (lat_cnt == LAT_W'(RD_LAT));

  logic unused_inputs;
  generate
    if (ADDR_W < 32) begin : g_addr_unused
      assign unused_inputs = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], rle_size[1:0]};
    end else begin : g_addr_full
      assign unused_inputs = ^rle_size[1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    port_A_we      = 1'b0;
    port_A_addr    = '0;
    port_A_data_in = '0;
    case (state)
      IDLE: begin
        // A size below one word has nothing to fetch; treat it like an empty frame.
        if (start) state_nx = (rle_size[31:2] == 30'd0) ? FIN : FETCH;
      end
      FETCH: begin
        port_A_addr = rd_ptr;
        if (lat_hit) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = (entry[7:0] == 8'd0) ? NEXT : EXPAND;
      end
      EXPAND: begin
        if (lane == 2'd3)          state_nx = WRITE;
        else if (run_left == 8'd1) state_nx = NEXT;
      end
      WRITE: begin
        port_A_we      = 1'b1;
        port_A_addr    = wr_ptr;
        port_A_data_in = pack;
        state_nx       = (run_left != 8'd0) ? EXPAND : NEXT;
      end
      NEXT: begin
        if (!half)                    state_nx = LOAD;
        else if (words_left != 30'd0) state_nx = FETCH;
        else if (lane != 2'd0)        state_nx = FLUSH;
        else                          state_nx = FIN;
      end
      FLUSH: begin
        port_A_we      = 1'b1;
        port_A_addr    = wr_ptr;
        port_A_data_in = pack;
        state_nx       = FIN;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      words_left   <= '0;
      byte_cnt     <= '0;
      lane         <= '0;
      half         <= 1'b0;
      cur_word     <= '0;
      run_byte     <= '0;
      run_left     <= '0;
      pack         <= '0;
      lat_cnt      <= '0;
      message_size <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_ptr     <= rle_addr[ADDR_W-1:0];
            wr_ptr     <= message_addr[ADDR_W-1:0];
            words_left <= rle_size[31:2];
            byte_cnt   <= '0;
            lane       <= '0;
            half       <= 1'b0;
            pack       <= '0;
            lat_cnt    <= '0;
            done       <= 1'b0;
          end
        end
        FETCH: begin
          if (lat_hit) begin
            cur_word   <= port_A_data_out;
            rd_ptr     <= rd_ptr + ADDR_W'(4);
            words_left <= words_left - 30'd1;
            half       <= 1'b0;
            lat_cnt    <= '0;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        LOAD: begin
          run_byte <= entry[15:8];
          run_left <= entry[7:0];
        end
        EXPAND: begin
          pack[{lane, 3'b000} +: 8] <= run_byte;
          lane     <= lane + 2'd1;
          byte_cnt <= byte_cnt + 32'd1;
          run_left <= run_left - 8'd1;
        end
        WRITE, FLUSH: begin
          wr_ptr <= wr_ptr + ADDR_W'(4);
          pack   <= '0;
        end
        NEXT: begin
          if (!half) half <= 1'b1;
        end
        FIN: begin
          message_size <= byte_cnt;
          done         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rle_decode.sv
`default_nettype none
// ============================================================================
// tb_rle_decode: vector table, hand-written corner sequences and randomized
// frames checked against a queue-based expansion model.   Rev 1.0
// ============================================================================
module tb_rle_decode;

  localparam int ADDR_W    = 16;
  localparam int MEM_WORDS = 1 << (ADDR_W - 2);
  localparam logic [31:0] RA = 32'h0000_0100;
  localparam logic [31:0] MA = 32'h0000_2000;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       rle_addr = '0, rle_size = '0, message_addr = '0;
  logic [31:0]       message_size;
  logic              done;
  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic              port_A_we;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;

  rle_decode #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
    .message_size(message_size), .done(done),
    .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle read latency, plus a backdoor load port.
  logic [31:0]       mem [0:MEM_WORDS-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-3:0] bd_idx = '0;
  logic [31:0]       bd_data = '0;
  int                write_cnt = 0;

  always @(posedge clk) begin
    port_A_data_out <= mem[port_A_addr[ADDR_W-1:2]];
    if (port_A_we) begin
      mem[port_A_addr[ADDR_W-1:2]] <= port_A_data_in;
      write_cnt <= write_cnt + 1;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  typedef struct packed {
    logic [3:0][31:0] in_w;
    logic [31:0]      n_in;
    logic [3:0][31:0] exp_w;
    logic [31:0]      n_out;
    logic [31:0]      exp_size;
  } vec_t;

  vec_t        vec [0:5];
  int          tests = 0;
  int          fails = 0;
  int          last_writes;
  int          nout, bad, len, nw, cnt;
  logic [7:0]  b, got, expb;
  logic [31:0] wd, rtop, ra, ma;
  logic [7:0]  exp_q[$];
  logic [15:0] ent_q[$];
  logic [7:0]  frame [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bd_write(input int widx, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_idx  = widx[ADDR_W-3:0];
    bd_data = d;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic run_decode(input logic [31:0] ra_i, input logic [31:0] rs_i,
                            input logic [31:0] ma_i, input bit poke);
    int base, cyc;
    base         = write_cnt;
    rle_addr     = ra_i;
    rle_size     = rs_i;
    message_addr = ma_i;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 20000) begin
      if (poke && cyc == 7) begin
        start    = 1'b1;
        rle_addr = 32'h0000_4000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_reached", {31'b0, done}, 32'd1);
    last_writes = write_cnt - base;
  endtask

  // Expected bytes in exp_q, output at MA (low ADDR_W bits); zero-padded tail.
  task automatic check_output(input string name);
    nout = (exp_q.size() + 3) / 4;
    check({name, "_size"}, message_size, exp_q.size());
    check({name, "_writes"}, last_writes, nout);
    bad = 0;
    for (int j = 0; j < nout * 4; j++) begin
      wd   = mem[(MA / 4) + (j / 4)];
      got  = wd[8 * (j % 4) +: 8];
      expb = (j < exp_q.size()) ? exp_q[j] : 8'h00;
      if (got !== expb) bad++;
    end
    check({name, "_bad_bytes"}, bad, 0);
    check({name, "_guard"}, mem[(MA / 4) + nout], GARBAGE);
  endtask

  task automatic prep_out(input int words);
    for (int k = 0; k < words; k++) bd_write((MA / 4) + k, GARBAGE);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) vec[i] = '0;
    vec[0].in_w[0] = 32'h0000_4104; vec[0].n_in = 1;
    vec[0].exp_w[0] = 32'h4141_4141; vec[0].n_out = 1; vec[0].exp_size = 4;
    vec[1].in_w[0] = 32'h0000_4205; vec[1].n_in = 1;
    vec[1].exp_w[0] = 32'h4242_4242; vec[1].exp_w[1] = 32'h0000_0042;
    vec[1].n_out = 2; vec[1].exp_size = 5;
    vec[2].in_w[0] = 32'h4302_4103; vec[2].n_in = 1;
    vec[2].exp_w[0] = 32'h4341_4141; vec[2].exp_w[1] = 32'h0000_0043;
    vec[2].n_out = 2; vec[2].exp_size = 5;
    vec[3].in_w[0] = 32'h1234_5678; vec[3].n_in = 0;
    vec[3].n_out = 0; vec[3].exp_size = 0;
    vec[4].in_w[0] = 32'h1100_2200; vec[4].n_in = 1;
    vec[4].n_out = 0; vec[4].exp_size = 0;
    vec[5].in_w[0] = 32'h4401_0000; vec[5].in_w[1] = 32'h4603_4502; vec[5].n_in = 2;
    vec[5].exp_w[0] = 32'h4645_4544; vec[5].exp_w[1] = 32'h0000_4646;
    vec[5].n_out = 2; vec[5].exp_size = 6;

    // Reset state; a start while held in reset is ignored.
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    rle_size = 32'd4;
    @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_we", {31'b0, port_A_we}, 32'd0);
    check("rst_size", message_size, 32'd0);
    check("rst_addr", {16'b0, port_A_addr}, 32'd0);
    start = 1'b0;
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_start", {31'b0, done}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) bd_write((RA / 4) + k, vec[i].in_w[k]);
      prep_out(5);
      run_decode(RA, vec[i].n_in * 4, MA, 1'b0);
      check($sformatf("v%0d_size", i), message_size, vec[i].exp_size);
      check($sformatf("v%0d_writes", i), last_writes, vec[i].n_out);
      for (int k = 0; k < 4; k++)
        if (k < int'(vec[i].n_out))
          check($sformatf("v%0d_word%0d", i, k), mem[(MA / 4) + k], vec[i].exp_w[k]);
      check($sformatf("v%0d_guard", i), mem[(MA / 4) + int'(vec[i].n_out)], GARBAGE);
    end

    // 255-byte run, padding entry, then one more byte: 256 zero bytes, 64 words.
    bd_write(RA / 4, 32'h0000_00FF);
    bd_write((RA / 4) + 1, 32'h0001_0000);
    prep_out(130);
    run_decode(RA, 32'd8, MA, 1'b0);
    exp_q.delete();
    repeat (256) exp_q.push_back(8'h00);
    check_output("max_run");

    // Both halves at maximum count: 511 bytes, last word partially filled.
    bd_write(RA / 4, 32'h00FF_00FF);
    prep_out(130);
    run_decode(RA, 32'd8, MA, 1'b0);
    exp_q.delete();
    repeat (511) exp_q.push_back(8'h00);
    check_output("max_two");

    // Randomized entry streams against the expansion model.
    for (int it = 0; it < 6; it++) begin
      nw = $urandom_range(1, 6);
      ent_q.delete();
      for (int e = 0; e < 2 * nw; e++) begin
        cnt = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
        if (it == 2 && e == 0) cnt = 200;
        b = 8'($urandom_range(0, 255));
        ent_q.push_back({b, cnt[7:0]});
      end
      exp_q.delete();
      foreach (ent_q[e]) repeat (int'(ent_q[e][7:0])) exp_q.push_back(ent_q[e][15:8]);
      for (int k = 0; k < nw; k++) bd_write((RA / 4) + k, {ent_q[2 * k + 1], ent_q[2 * k]});
      prep_out((exp_q.size() + 3) / 4 + 1);
      rtop = $urandom;
      ra = {rtop[31:16], RA[15:0]};
      rtop = $urandom;
      ma = {rtop[31:16], MA[15:0]};
      run_decode(ra, nw * 4, ma, it == 2);
      check_output($sformatf("rand%0d", it));
    end

    // Round trip: run-structured 64-byte frame, encoded here, decoded by the DUT.
    begin
      int i;
      i = 0;
      while (i < 64) begin
        b = 8'($urandom_range(0, 255));
        len = $urandom_range(1, 12);
        for (int j = 0; j < len && i < 64; j++) begin
          frame[i] = b;
          i++;
        end
      end
      ent_q.delete();
      i = 0;
      while (i < 64) begin
        b = frame[i];
        len = 0;
        while (i < 64 && frame[i] == b && len < 255) begin
          i++;
          len++;
        end
        ent_q.push_back({b, 8'(len)});
      end
      if (ent_q.size() % 2 != 0) ent_q.push_back(16'h0000);
      for (int k = 0; k < ent_q.size() / 2; k++)
        bd_write((RA / 4) + k, {ent_q[2 * k + 1], ent_q[2 * k]});
      exp_q.delete();
      for (int j = 0; j < 64; j++) exp_q.push_back(frame[j]);
      prep_out(17);
      run_decode(RA, ent_q.size() * 2, MA, 1'b0);
      check_output("roundtrip");
    end

    // Abort mid-expansion, then a fresh decode.
    bd_write(RA / 4, 32'h66FF_77FF);
    rle_addr = RA;
    rle_size = 32'd4;
    message_addr = MA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_we", {31'b0, port_A_we}, 32'd0);
    check("abort_size", message_size, 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    bd_write(RA / 4, 32'h0000_4104);
    prep_out(2);
    run_decode(RA, 32'd4, MA, 1'b0);
    exp_q.delete();
    repeat (4) exp_q.push_back(8'h41);
    check_output("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
